uart_rx_cfg: RTL and testbench

Parametrised next-generation UART receiver. Supports configurable baud divisor, data width, optional parity and stop-bit checking. Reports framing, parity and overrun errors, and rejects false start bits caused by line glitches. Sits between the external RX pin and the command/packet layer, using the same rdy/clr_rdy handshake as the existing receive path.

---
 rtl/uart_rx_cfg.sv | 148 ++++++++++++++
 tb/tb_uart_rx_cfg.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with false-start rejection and frame/parity/overrun flags.
// Optional define UART_RX_MAJORITY_EN selects a 2-of-3 majority vote around each mid-bit sample.
module uart_rx_cfg #(
    parameter int CLK_DIV   = 2604,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    localparam logic [11:0] HALF_LOAD = 12'(CLK_DIV / 2 - 1);
    localparam logic [11:0] FULL_LOAD = 12'(CLK_DIV - 1);
    localparam int          BCW       = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR_BIT,
        STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [11:0]          baud_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic                 tick;
    logic                 step;
    logic                 bit_val;
    logic                 data_xor;
    logic                 par_mismatch;

    // Two-flop synchroniser; the line idles high so the flops reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (state != IDLE) && (baud_cnt == 12'd0);

`ifdef UART_RX_MAJORITY_EN
    logic samp_pre;
    logic samp_mid;

    // Votes use the samples at counts 1 and 0 plus the live one, so bit decisions land a cycle after the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_pre <= 1'b1;
            samp_mid <= 1'b1;
        end else if (state != IDLE) begin
            if (baud_cnt == 12'd1)
                samp_pre <= rx_s;
            if (baud_cnt == 12'd0)
                samp_mid <= rx_s;
        end
    end

    assign step    = (state != IDLE) && (baud_cnt == FULL_LOAD);
    assign bit_val = (samp_pre & samp_mid) | (samp_pre & rx_s) | (samp_mid & rx_s);
`else
    assign step    = tick;
    assign bit_val = rx_s;
`endif

    assign data_xor     = ^{shift_reg, par_bit};
    assign par_mismatch = (PARITY == 1) ? ~data_xor :
                          (PARITY == 2) ?  data_xor : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= 12'd0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rdy        <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end

            if (state == IDLE) begin
                if (!rx_s) begin
                    state    <= START;
                    baud_cnt <= HALF_LOAD;
                    bit_cnt  <= '0;
                end
            end else if (tick) begin
                baud_cnt <= FULL_LOAD;
            end else begin
                baud_cnt <= baud_cnt - 12'd1;
            end

            // Completion assignments come after the clr_rdy block so a same-cycle completion wins.
            if (step) begin
                case (state)
                    START: begin
                        state <= bit_val ? IDLE : DATA;
                    end
                    DATA: begin
                        shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + BCW'(1);
                        if (bit_cnt == LAST_BIT)
                            state <= (PARITY != 0) ? PAR_BIT : STOP;
                    end
                    PAR_BIT: begin
                        par_bit <= bit_val;
                        state   <= STOP;
                    end
                    STOP: begin
                        state      <= IDLE;
                        rx_data    <= shift_reg;
                        rdy        <= 1'b1;
                        frame_err  <= ~bit_val;
                        parity_err <= par_mismatch;
                        if (rdy)
                            overrun <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: three receiver lanes (8N1, 8E1, 5O1) driven with directed and random frames.
// A frame-level model predicts the completion cycle and outputs of every lane.
module tb_uart_rx_cfg;
    localparam int CLK_DIV = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx    = 3'b111;
    logic [2:0] clr   = 3'b000;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [4:0] data2;
    logic [2:0] rdy_o;
    logic [2:0] ferr_o;
    logic [2:0] perr_o;
    logic [2:0] ovr_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    // Model state: expected outputs plus one pending completion per lane.
    logic [8:0] m_data [3];
    logic [2:0] m_rdy  = '0;
    logic [2:0] m_ferr = '0;
    logic [2:0] m_perr = '0;
    logic [2:0] m_ovr  = '0;
    logic [2:0] pend_v = '0;
    int         pend_cyc [3];
    logic [8:0] pend_data [3];
    logic [2:0] pend_perr = '0;
    logic [2:0] pend_ferr = '0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .RX(rx[0]), .clr_rdy(clr[0]), .rx_data(data0),
        .rdy(rdy_o[0]), .frame_err(ferr_o[0]), .parity_err(perr_o[0]), .overrun(ovr_o[0]));

    uart_rx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .RX(rx[1]), .clr_rdy(clr[1]), .rx_data(data1),
        .rdy(rdy_o[1]), .frame_err(ferr_o[1]), .parity_err(perr_o[1]), .overrun(ovr_o[1]));

    uart_rx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(5), .PARITY(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .RX(rx[2]), .clr_rdy(clr[2]), .rx_data(data2),
        .rdy(rdy_o[2]), .frame_err(ferr_o[2]), .parity_err(perr_o[2]), .overrun(ovr_o[2]));

    function automatic int dbOf(input int l);
        return (l == 2) ? 5 : 8;
    endfunction

    function automatic int parOf(input int l);
        return (l == 0) ? 0 : ((l == 1) ? 2 : 1);
    endfunction

    function automatic logic [8:0] dutData(input int l);
        case (l)
            0:       return {1'b0, data0};
            1:       return {1'b0, data1};
            default: return {4'b0, data2};
        endcase
    endfunction

    // Cycle counter and frame-level model, advanced on every rising edge.
    always @(posedge clk) begin
        cyc++;
        for (int l = 0; l < 3; l++) begin
            if (!rst_n) begin
                m_data[l] = '0;
                m_rdy[l]  = 1'b0;
                m_ferr[l] = 1'b0;
                m_perr[l] = 1'b0;
                m_ovr[l]  = 1'b0;
            end else if (pend_v[l] && pend_cyc[l] == cyc) begin
                if (m_rdy[l])
                    m_ovr[l] = 1'b1;
                m_rdy[l]  = 1'b1;
                m_data[l] = pend_data[l];
                m_ferr[l] = pend_ferr[l];
                m_perr[l] = pend_perr[l];
            end else if (clr[l]) begin
                m_rdy[l] = 1'b0;
                m_ovr[l] = 1'b0;
            end
        end
    end

    task automatic checkVal(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        for (int l = 0; l < 3; l++) begin
            logic [8:0] ed;
            logic       er, ef, ep, eo;
            ed = rst_n ? m_data[l] : 9'd0;
            er = rst_n & m_rdy[l];
            ef = rst_n & m_ferr[l];
            ep = rst_n & m_perr[l];
            eo = rst_n & m_ovr[l];
            checks++;
            if (dutData(l) !== ed || rdy_o[l] !== er || ferr_o[l] !== ef ||
                perr_o[l] !== ep || ovr_o[l] !== eo) begin
                failures++;
                if (failures <= 30)
                    $display("[TB] FAIL lane%0d cyc=%0d got data=%h rdy=%b fe=%b pe=%b ov=%b expected data=%h rdy=%b fe=%b pe=%b ov=%b",
                             l, cyc, dutData(l), rdy_o[l], ferr_o[l], perr_o[l], ovr_o[l], ed, er, ef, ep, eo);
            end
        end
    endtask

    task automatic waitCyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic driveBit(input int l, input logic b);
        rx[l] = b;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int l, input int n);
        rx[l] = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseClr(input int l);
        clr[l] = 1'b1;
        @(posedge clk);
        #1;
        clr[l] = 1'b0;
    endtask

    // Called #1 after a rising edge; the model expects rdy at mid-stop plus 3 cycles of sync/register latency.
    task automatic applyStimulus(input int l, input logic [8:0] d, input bit par_bad, input bit stop_bad);
        int         db = dbOf(l);
        int         pm = parOf(l);
        logic [8:0] dm;
        logic       pbit;
        int         nb;
        dm   = d & ((9'd1 << db) - 9'd1);
        nb   = 1 + db + ((pm != 0) ? 1 : 0);
        pbit = (pm == 2) ? (($countones(dm) % 2) == 1) : (($countones(dm) % 2) == 0);
        pbit = pbit ^ par_bad;
        pend_data[l] = dm;
        pend_perr[l] = (pm != 0) && par_bad;
        pend_ferr[l] = stop_bad;
        pend_cyc[l]  = cyc + CLK_DIV / 2 + 3 + CLK_DIV * nb;
        pend_v[l]    = 1'b1;
        driveBit(l, 1'b0);
        for (int i = 0; i < db; i++)
            driveBit(l, dm[i]);
        if (pm != 0)
            driveBit(l, pbit);
        driveBit(l, !stop_bad);
        if (stop_bad)
            idleCycles(l, CLK_DIV);
    endtask

    task automatic glitch(input int l, input int w);
        rx[l] = 1'b0;
        repeat (w) @(posedge clk);
        #1;
        idleCycles(l, CLK_DIV);
    endtask

    task automatic randomLane(input int l, input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(9) == 0)
                glitch(l, $urandom_range(5, 1));
            else
                applyStimulus(l, 9'($urandom), ($urandom_range(5) == 0), ($urandom_range(7) == 0));
            if ($urandom_range(2) == 0)
                idleCycles(l, $urandom_range(20));
        end
        done_cnt++;
    endtask

    initial begin
        int t0;
        for (int l = 0; l < 3; l++) m_data[l] = '0;

        fork
            forever begin
                @(negedge clk);
                checkOutput();
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("reset rdy", {8'd0, rdy_o[0]}, 9'd0);
        checkVal("reset data", dutData(0), 9'd0);
        @(posedge clk);
        #1;

        $display("[TB] 0xA5 on 8N1 lane");
        t0 = cyc;
        fork
            applyStimulus(0, 9'h0A5, 1'b0, 1'b0);
            begin
                waitCyc(t0 + 154);
                checkVal("A5 rdy before stop tick", {8'd0, rdy_o[0]}, 9'd0);
                waitCyc(t0 + 155);
                checkVal("A5 rdy", {8'd0, rdy_o[0]}, 9'd1);
                checkVal("A5 data", dutData(0), 9'h0A5);
                checkVal("A5 frame_err", {8'd0, ferr_o[0]}, 9'd0);
                checkVal("A5 parity_err", {8'd0, perr_o[0]}, 9'd0);
            end
        join

        $display("[TB] back-to-back 0x3C 0xC3");
        pulseClr(0);
        applyStimulus(0, 9'h03C, 1'b0, 1'b0);
        applyStimulus(0, 9'h0C3, 1'b0, 1'b0);
        checkVal("overrun data", dutData(0), 9'h0C3);
        checkVal("overrun flag", {8'd0, ovr_o[0]}, 9'd1);
        pulseClr(0);
        @(negedge clk);
        checkVal("clr rdy", {8'd0, rdy_o[0]}, 9'd0);
        checkVal("clr overrun", {8'd0, ovr_o[0]}, 9'd0);
        @(posedge clk);
        #1;

        $display("[TB] 4-cycle glitch");
        glitch(0, 4);
        checkVal("glitch rdy", {8'd0, rdy_o[0]}, 9'd0);
        checkVal("glitch frame_err", {8'd0, ferr_o[0]}, 9'd0);
        checkVal("glitch data kept", dutData(0), 9'h0C3);

        $display("[TB] even parity 0x07");
        applyStimulus(1, 9'h007, 1'b1, 1'b0);
        checkVal("bad parity flag", {8'd0, perr_o[1]}, 9'd1);
        checkVal("bad parity rdy", {8'd0, rdy_o[1]}, 9'd1);
        checkVal("bad parity data", dutData(1), 9'h007);
        pulseClr(1);
        applyStimulus(1, 9'h007, 1'b0, 1'b0);
        checkVal("good parity flag", {8'd0, perr_o[1]}, 9'd0);

        $display("[TB] stop bit held low");
        applyStimulus(0, 9'h055, 1'b0, 1'b1);
        checkVal("framing flag", {8'd0, ferr_o[0]}, 9'd1);
        checkVal("framing rdy", {8'd0, rdy_o[0]}, 9'd1);
        pulseClr(0);
        applyStimulus(0, 9'h012, 1'b0, 1'b0);
        checkVal("after framing flag", {8'd0, ferr_o[0]}, 9'd0);
        checkVal("after framing data", dutData(0), 9'h012);

        $display("[TB] reset mid-frame");
        rx = 3'b000;
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx    = 3'b111;
        @(negedge clk);
        checkVal("in-reset rdy", {6'd0, rdy_o}, 9'd0);
        checkVal("in-reset data", dutData(1), 9'd0);
        checkVal("in-reset flags", {3'd0, ferr_o, ovr_o}, 9'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycles(0, CLK_DIV);
        fork
            applyStimulus(0, 9'h081, 1'b0, 1'b0);
            applyStimulus(1, 9'h081, 1'b0, 1'b0);
            applyStimulus(2, 9'h081, 1'b0, 1'b0);
        join
        checkVal("post-reset data", dutData(0), 9'h081);
        checkVal("post-reset rdy", {8'd0, rdy_o[0]}, 9'd1);

        $display("[TB] random frames");
        fork
            randomLane(0, 30);
            randomLane(1, 30);
            randomLane(2, 30);
            begin
                while (done_cnt < 3) begin
                    clr = {($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0)};
                    @(posedge clk);
                    #1;
                end
                clr = 3'b000;
            end
        join
        idleCycles(0, 4 * CLK_DIV);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
